donut_frame_streamer: RTL and testbench

Upstream byte source for the UART transmitter: walks a COLS×ROWS character grid and emits one terminal frame per pass. Each frame is an ANSI cursor-home header, then each row's characters, each row ending in CR LF. Character values come from a 4-bit luminance supplied by the renderer for the current (pix_x, pix_y). Bytes are handed over through the transmitter's start/txe handshake.

---
 rtl/donut_frame_streamer.sv | 246 ++++++++++++++++++++++++
 tb/tb_donut_frame_streamer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/donut_frame_streamer.sv
// donut_frame_streamer
// --------------------
// Byte source for the UART transmitter. Each pass over the COLS x ROWS
// character grid produces one terminal frame: an ANSI cursor-home header
// (optionally preceded by a screen clear), then every row's characters,
// each row terminated by CR LF. Character codes come from a 4-bit
// luminance that the renderer supplies combinationally for the current
// (pix_x, pix_y).
//
// Optional feature macro: DONUT_FRAME_CLEAR_EN
//   defined   -> 7-byte header ESC[2J ESC[H (screen cleared every frame)
//   undefined -> 3-byte header ESC[H
//
// Ports
//   clk         system clock
//   nrst        asynchronous active-low reset
//   run         frame enable, only looked at while idle
//   lum[3:0]    luminance for current pix_x/pix_y (0..11 shaded, 12..15 blank)
//   txe         transmitter ready; a byte is consumed when start && txe
//   start       a byte is available on data_out
//   data_out    byte to transmit
//   pix_x[6:0]  current column
//   pix_y[4:0]  current row
//   frame_done  one-cycle pulse after the final LF of a frame is consumed

module donut_frame_streamer #(
  parameter int COLS = 80,
  parameter int ROWS = 24
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       run,
  input  logic [3:0] lum,
  input  logic       txe,
  output logic       start,
  output logic [7:0] data_out,
  output logic [6:0] pix_x,
  output logic [4:0] pix_y,
  output logic       frame_done
);

`ifdef DONUT_FRAME_CLEAR_EN
  localparam int HDR_LEN = 7;
`else
  localparam int HDR_LEN = 3;
`endif
  localparam int HDR_W = $clog2(HDR_LEN);

  localparam logic [HDR_W-1:0] HDR_LAST = HDR_W'(HDR_LEN - 1);
  localparam logic [HDR_W-1:0] HDR_ZERO = HDR_W'(0);
  localparam logic [HDR_W-1:0] HDR_ONE  = HDR_W'(1);
  localparam logic [6:0]       COL_LAST = 7'(COLS - 1);
  localparam logic [4:0]       ROW_LAST = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PIX  = 3'd2,
    S_CR   = 3'd3,
    S_LF   = 3'd4
  } state_t;

  // Header byte lookup; index is widened to 3 bits so both header lengths
  // share one table shape.
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
`ifdef DONUT_FRAME_CLEAR_EN
      3'd0:    b = 8'h1B;
      3'd1:    b = 8'h5B;
      3'd2:    b = 8'h32;
      3'd3:    b = 8'h4A;
      3'd4:    b = 8'h1B;
      3'd5:    b = 8'h5B;
      3'd6:    b = 8'h48;
`else
      3'd0:    b = 8'h1B;
      3'd1:    b = 8'h5B;
      3'd2:    b = 8'h48;
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Luminance ramp ".,-~:;=!*#$@"; out-of-range luminance renders as space.
  function automatic logic [7:0] charmap(input logic [3:0] l);
    logic [7:0] c;
    case (l)
      4'd0:    c = 8'h2E;
      4'd1:    c = 8'h2C;
      4'd2:    c = 8'h2D;
      4'd3:    c = 8'h7E;
      4'd4:    c = 8'h3A;
      4'd5:    c = 8'h3B;
      4'd6:    c = 8'h3D;
      4'd7:    c = 8'h21;
      4'd8:    c = 8'h2A;
      4'd9:    c = 8'h23;
      4'd10:   c = 8'h24;
      4'd11:   c = 8'h40;
      default: c = 8'h20;
    endcase
    return c;
  endfunction

  state_t           state_r, state_nx_s;
  logic [HDR_W-1:0] hdr_idx_r, hdr_idx_nx_s;
  logic [6:0]       pix_x_r, pix_x_nx_s;
  logic [4:0]       pix_y_r, pix_y_nx_s;
  logic             frame_done_r, frame_done_nx_s;
  logic             start_s;
  logic [7:0]       data_out_s;
  logic             consume_s;

  assign consume_s = start_s & txe;

  // Byte presented to the transmitter, derived from current state and lum.
  always_comb begin
    start_s    = 1'b0;
    data_out_s = 8'h00;
    case (state_r)
      S_IDLE: begin
        start_s    = 1'b0;
        data_out_s = 8'h00;
      end
      S_HDR: begin
        start_s    = 1'b1;
        data_out_s = hdr_byte(3'(hdr_idx_r));
      end
      S_PIX: begin
        start_s    = 1'b1;
        data_out_s = charmap(lum);
      end
      S_CR: begin
        start_s    = 1'b1;
        data_out_s = 8'h0D;
      end
      S_LF: begin
        start_s    = 1'b1;
        data_out_s = 8'h0A;
      end
      default: begin
        start_s    = 1'b0;
        data_out_s = 8'h00;
      end
    endcase
  end

  // Next-state and counter update; everything holds unless a byte is consumed.
  always_comb begin
    state_nx_s      = state_r;
    hdr_idx_nx_s    = hdr_idx_r;
    pix_x_nx_s      = pix_x_r;
    pix_y_nx_s      = pix_y_r;
    frame_done_nx_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (run) begin
          state_nx_s   = S_HDR;
          hdr_idx_nx_s = HDR_ZERO;
          pix_x_nx_s   = 7'd0;
          pix_y_nx_s   = 5'd0;
        end else begin
          state_nx_s   = S_IDLE;
        end
      end
      S_HDR: begin
        if (consume_s) begin
          if (hdr_idx_r == HDR_LAST) begin
            state_nx_s   = S_PIX;
            hdr_idx_nx_s = HDR_ZERO;
          end else begin
            hdr_idx_nx_s = hdr_idx_r + HDR_ONE;
          end
        end else begin
          state_nx_s = S_HDR;
        end
      end
      S_PIX: begin
        if (consume_s) begin
          if (pix_x_r == COL_LAST) begin
            pix_x_nx_s = 7'd0;
            state_nx_s = S_CR;
          end else begin
            pix_x_nx_s = pix_x_r + 7'd1;
          end
        end else begin
          state_nx_s = S_PIX;
        end
      end
      S_CR: begin
        if (consume_s) begin
          state_nx_s = S_LF;
        end else begin
          state_nx_s = S_CR;
        end
      end
      S_LF: begin
        if (consume_s) begin
          if (pix_y_r == ROW_LAST) begin
            pix_y_nx_s      = 5'd0;
            frame_done_nx_s = 1'b1;
            state_nx_s      = S_IDLE;
          end else begin
            pix_y_nx_s = pix_y_r + 5'd1;
            state_nx_s = S_PIX;
          end
        end else begin
          state_nx_s = S_LF;
        end
      end
      default: begin
        state_nx_s      = S_IDLE;
        hdr_idx_nx_s    = HDR_ZERO;
        pix_x_nx_s      = 7'd0;
        pix_y_nx_s      = 5'd0;
        frame_done_nx_s = 1'b0;
      end
    endcase
  end

  // State and counter registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r      <= S_IDLE;
      hdr_idx_r    <= HDR_ZERO;
      pix_x_r      <= 7'd0;
      pix_y_r      <= 5'd0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      hdr_idx_r    <= hdr_idx_nx_s;
      pix_x_r      <= pix_x_nx_s;
      pix_y_r      <= pix_y_nx_s;
      frame_done_r <= frame_done_nx_s;
    end
  end

  assign start      = start_s;
  assign data_out   = data_out_s;
  assign pix_x      = pix_x_r;
  assign pix_y      = pix_y_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_donut_frame_streamer.sv
// Directed bench for donut_frame_streamer with a 4x2 grid. Works for both
// the default build and a DONUT_FRAME_CLEAR_EN build.

module tb_donut_frame_streamer;

  localparam int COLS = 4;
  localparam int ROWS = 2;
`ifdef DONUT_FRAME_CLEAR_EN
  localparam int H = 7;
`else
  localparam int H = 3;
`endif
  localparam int NB = H + ROWS * (COLS + 2);

  logic       clk;
  logic       nrst;
  logic       run;
  logic [3:0] lum;
  logic       txe;
  logic       start;
  logic [7:0] data_out;
  logic [6:0] pix_x;
  logic [4:0] pix_y;
  logic       frame_done;

  logic       lum_mode;
  logic [3:0] lum_c;

  int n_checks = 0;
  int n_fail   = 0;

  // Renderer stand-in: constant luminance, or pix_x + 4*pix_y.
  assign lum = lum_mode ? (pix_x[3:0] + {pix_y[1:0], 2'b00}) : lum_c;

  donut_frame_streamer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .run        (run),
    .lum        (lum),
    .txe        (txe),
    .start      (start),
    .data_out   (data_out),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumed-byte recorder and frame_done tracker, sampled mid-cycle.
  logic [7:0] byte_q[$];
  logic [6:0] x_q[$];
  logic [4:0] y_q[$];
  int         fd_cyc[$];
  int         fd_cnt = 0;
  int         cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (start && txe) begin
      byte_q.push_back(data_out);
      x_q.push_back(pix_x);
      y_q.push_back(pix_y);
    end
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_cyc.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int bound, input string tag);
    int k;
    k = 0;
    while (fd_cnt < target && k < bound) begin
      tick();
      k++;
    end
    check_val(tag, 32'(fd_cnt >= target), 32'd1);
  endtask

  // Expected byte i of a frame; mode 0 = all lum 0, mode 1 = ramp pattern.
  function automatic logic [7:0] exp_byte(input int mode, input int i);
`ifdef DONUT_FRAME_CLEAR_EN
    logic [7:0] hdr [7] = '{8'h1B, 8'h5B, 8'h32, 8'h4A, 8'h1B, 8'h5B, 8'h48};
`else
    logic [7:0] hdr [3] = '{8'h1B, 8'h5B, 8'h48};
`endif
    logic [7:0] row0 [4] = '{8'h2E, 8'h2C, 8'h2D, 8'h7E};
    logic [7:0] row1 [4] = '{8'h3A, 8'h3B, 8'h3D, 8'h21};
    int j, r, c;
    if (i < H) return hdr[i];
    j = i - H;
    r = j / (COLS + 2);
    c = j % (COLS + 2);
    if (c == COLS)     return 8'h0D;
    if (c == COLS + 1) return 8'h0A;
    if (mode == 0)     return 8'h2E;
    return (r == 0) ? row0[c] : row1[c];
  endfunction

  task automatic check_bytes(input int mode, input string tag);
    check_val({tag, "_count"}, 32'(byte_q.size()), 32'(NB));
    for (int i = 0; i < NB && i < byte_q.size(); i++) begin
      check_val($sformatf("%s_b%0d", tag, i), byte_q[i], exp_byte(mode, i));
    end
  endtask

  logic [7:0] chr_exp [16] = '{8'h2E, 8'h2C, 8'h2D, 8'h7E, 8'h3A, 8'h3B, 8'h3D, 8'h21,
                               8'h2A, 8'h23, 8'h24, 8'h40, 8'h20, 8'h20, 8'h20, 8'h20};

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int         k, gap, burst, fd_before;
    logic [7:0] ref_b;

    nrst = 1'b0; run = 1'b0; txe = 1'b1; lum_mode = 1'b0; lum_c = 4'd0;
    tick();
    tick();
    // Reset state
    check_val("rst_start", start, 1'b0);
    check_val("rst_data", data_out, 8'h00);
    check_val("rst_x", pix_x, 7'd0);
    check_val("rst_y", pix_y, 5'd0);
    check_val("rst_fd", frame_done, 1'b0);
    nrst = 1'b1;
    tick();
    check_val("idle_start", start, 1'b0);

    // Test 1: constant lum 0, txe always high
    byte_q.delete();
    pulse_run();
    check_val("t1_first_start", start, 1'b1);
    check_val("t1_first_byte", data_out, 8'h1B);
    wait_fd(1, 60, "t1_fd_seen");
    tick();
    tick();
    check_bytes(0, "t1");
    check_val("t1_start_after", start, 1'b0);
    check_val("t1_fd_once", 32'(fd_cnt), 32'd1);

    // Test 2: ramp luminance, coordinates in step with consumes
    byte_q.delete(); x_q.delete(); y_q.delete();
    lum_mode = 1'b1;
    pulse_run();
    wait_fd(2, 60, "t2_fd_seen");
    check_bytes(1, "t2");
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        k = H + r * (COLS + 2) + c;
        if (k < x_q.size()) begin
          check_val($sformatf("t2_x_%0d_%0d", r, c), x_q[k], 32'(c));
          check_val($sformatf("t2_y_%0d_%0d", r, c), y_q[k], 32'(r));
        end else begin
          check_val("t2_coord_missing", 32'(x_q.size()), 32'(NB));
        end
      end
    end
    lum_mode = 1'b0;

    // Test 3: full charmap while parked on the first pixel
    byte_q.delete();
    txe = 1'b0;
    pulse_run();
    check_val("t3_hdr_start", start, 1'b1);
    txe = 1'b1;
    repeat (H) tick();
    txe = 1'b0;
    check_val("t3_px", pix_x, 7'd0);
    for (int v = 0; v < 16; v++) begin
      lum_c = 4'(v);
      #1;
      check_val($sformatf("t3_lum%0d", v), data_out, chr_exp[v]);
    end
    repeat (3) tick();
    check_val("t3_hold_x", pix_x, 7'd0);
    check_val("t3_hold_start", start, 1'b1);
    check_val("t3_hold_data", data_out, 8'h20);
    lum_c = 4'd0;
    txe = 1'b1;
    wait_fd(3, 60, "t3_fd_seen");
    check_bytes(0, "t3");

    // Test 4: txe toggling with gaps of 3..5 cycles
    byte_q.delete();
    txe = 1'b0;
    pulse_run();
    k = 0;
    while (fd_cnt < 4 && k < 100) begin
      gap = $urandom_range(3, 5);
      txe = 1'b0;
      #1;
      ref_b = data_out;
      repeat (gap) begin
        tick();
        check_val("t4_hold", data_out, ref_b);
      end
      txe = 1'b1;
      burst = $urandom_range(1, 3);
      repeat (burst) tick();
      k++;
    end
    txe = 1'b1;
    check_val("t4_fd_seen", 32'(fd_cnt >= 4), 32'd1);
    tick();
    tick();
    check_bytes(0, "t4");

    // Test 5: run held high, frame_done spacing
    fd_cyc.delete();
    run = 1'b1;
    wait_fd(7, 200, "t5_fd_seen");
    run = 1'b0;
    wait_fd(8, 60, "t5_drain");
    check_val("t5_pulses", 32'(fd_cyc.size() >= 3), 32'd1);
    if (fd_cyc.size() >= 3) begin
      check_val("t5_gap1", 32'(fd_cyc[1] - fd_cyc[0]), 32'(NB + 1));
      check_val("t5_gap2", 32'(fd_cyc[2] - fd_cyc[1]), 32'(NB + 1));
    end else begin
      check_val("t5_gap_missing", 32'(fd_cyc.size()), 32'd3);
    end

    // Test 6: reset after six consumes aborts the frame
    tick();
    byte_q.delete();
    txe = 1'b1;
    pulse_run();
    k = 0;
    while (byte_q.size() < 6 && k < 50) begin
      tick();
      k++;
    end
    check_val("t6_six", 32'(byte_q.size()), 32'd6);
    fd_before = fd_cnt;
    nrst = 1'b0;
    #1;
    check_val("t6_start", start, 1'b0);
    check_val("t6_x", pix_x, 7'd0);
    check_val("t6_y", pix_y, 5'd0);
    check_val("t6_fd", frame_done, 1'b0);
    tick();
    nrst = 1'b1;
    run = 1'b1;
    tick();
    check_val("t6_restart_start", start, 1'b1);
    check_val("t6_restart_byte", data_out, 8'h1B);
    check_val("t6_no_fd", 32'(fd_cnt), 32'(fd_before));
    run = 1'b0;
    wait_fd(fd_before + 1, 60, "t6_fd_seen");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
